// File: rtl/sram_test_pkg.sv
// sram_test_pkg: state encoding and data pattern shared by the SRAM tester and its benches.
// pattern() works on 32-bit operands; callers truncate the result to their data width.
package sram_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_END
  } state_t;

  function automatic logic [31:0] pattern(input logic [31:0] a, input logic [31:0] s);
    return a ^ s;
  endfunction

endpackage

// File: rtl/sram_tester_pipe.sv
// sram_tester_pipe: DEPTH-stage shift register of {valid, addr, expected} that lines up
// read expectations with the controller's read latency; i_flush empties every stage.
module sram_tester_pipe #(
  parameter int DEPTH     = 2,
  parameter int ADDR_BITS = 20,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_flush,
  input  logic                 i_valid,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [DATA_BITS-1:0] i_expected,
  output logic                 o_valid,
  output logic [ADDR_BITS-1:0] o_addr,
  output logic [DATA_BITS-1:0] o_expected
);

  localparam int W = 1 + ADDR_BITS + DATA_BITS;

  logic [W-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= {i_valid, i_addr, i_expected};
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign {o_valid, o_addr, o_expected} = r_stage[DEPTH-1];

endmodule

// File: rtl/sram_tester.sv
// sram_tester: writes a seeded address pattern to every address, reads it back through a
// latency-matched expectation pipe, captures the first mismatch and counts clean passes.
module sram_tester
  import sram_test_pkg::*;
#(
  parameter int          ADDR_BITS     = 20,
  parameter int          DATA_BITS     = 16,
  parameter int          MAX_ADDR      = 2**ADDR_BITS - 1,
  parameter logic [15:0] SEED          = 16'hA5C3,
  parameter int          READ_LATENCY  = 2,
  parameter bit          STOP_ON_ERROR = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 loop,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          pass_count,
  output logic                 error,
  output logic [ADDR_BITS-1:0] err_addr,
  output logic [DATA_BITS-1:0] err_expected,
  output logic [DATA_BITS-1:0] err_actual,
  output logic                 read_only,
  output logic [ADDR_BITS-1:0] addr,
  output logic [DATA_BITS-1:0] data_i,
  input  logic [DATA_BITS-1:0] data_o
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR  = ADDR_BITS'(MAX_ADDR);
  localparam logic [DATA_BITS-1:0] SEED_INIT  = DATA_BITS'(SEED);
  localparam int                   DRAIN_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [DRAIN_W-1:0]   LAST_DRAIN = DRAIN_W'(READ_LATENCY - 1);

  state_t                 r_state, w_nextState;
  logic [ADDR_BITS-1:0]   r_addr, w_nextAddr;
  logic [DATA_BITS-1:0]   r_seed;
  logic [DRAIN_W-1:0]     r_drainCnt;
  logic                   r_done, r_error;
  logic [15:0]            r_passCount;
  logic [ADDR_BITS-1:0]   r_errAddr;
  logic [DATA_BITS-1:0]   r_errExpected, r_errActual;
  logic [DATA_BITS-1:0]   w_pattern;
  logic                   w_accept, w_pushValid, w_flush, w_done, w_endClean, w_mismatch;
  logic                   w_tailValid;
  logic [ADDR_BITS-1:0]   w_tailAddr;
  logic [DATA_BITS-1:0]   w_tailExpected;

  assign w_pattern  = DATA_BITS'(pattern(32'(r_addr), 32'(r_seed)));
  assign w_mismatch = w_tailValid && (data_o != w_tailExpected);

  sram_tester_pipe #(
    .DEPTH     (READ_LATENCY),
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS)
  ) u_pipe (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_flush    (w_flush),
    .i_valid    (w_pushValid),
    .i_addr     (r_addr),
    .i_expected (w_pattern),
    .o_valid    (w_tailValid),
    .o_addr     (w_tailAddr),
    .o_expected (w_tailExpected)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_nextAddr  = r_addr;
    w_accept    = 1'b0;
    w_pushValid = 1'b0;
    w_flush     = 1'b0;
    w_done      = 1'b0;
    w_endClean  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = ST_WRITE;
          w_nextAddr  = '0;
        end
      end
      ST_WRITE: begin
        if (r_addr == LAST_ADDR) begin
          w_nextState = ST_READ;
          w_nextAddr  = '0;
        end else begin
          w_nextAddr = r_addr + 1'b1;
        end
      end
      ST_READ: begin
        w_pushValid = 1'b1;
        if (r_addr == LAST_ADDR) w_nextState = ST_DRAIN;
        else                     w_nextAddr  = r_addr + 1'b1;
      end
      ST_DRAIN: begin
        if (r_drainCnt == LAST_DRAIN) w_nextState = ST_END;
      end
      ST_END: begin
        w_endClean = !r_error;
        if (loop && !r_error) begin
          w_nextState = ST_WRITE;
          w_nextAddr  = '0;
        end else begin
          w_nextState = ST_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
    // An abort overrides whatever the phase wanted and discards in-flight reads.
    if (STOP_ON_ERROR && w_mismatch) begin
      w_nextState = ST_IDLE;
      w_flush     = 1'b1;
      w_done      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr        <= '0;
      r_seed        <= SEED_INIT;
      r_drainCnt    <= '0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_passCount   <= '0;
      r_errAddr     <= '0;
      r_errExpected <= '0;
      r_errActual   <= '0;
    end else begin
      r_addr     <= w_nextAddr;
      r_done     <= w_done;
      r_drainCnt <= (r_state == ST_DRAIN) ? r_drainCnt + 1'b1 : '0;
      if (w_accept) begin
        r_error       <= 1'b0;
        r_errAddr     <= '0;
        r_errExpected <= '0;
        r_errActual   <= '0;
      end else if (w_mismatch && !r_error) begin
        r_error       <= 1'b1;
        r_errAddr     <= w_tailAddr;
        r_errExpected <= w_tailExpected;
        r_errActual   <= data_o;
      end
      if (w_endClean) begin
        r_passCount <= r_passCount + 1'b1;
        r_seed      <= ~r_seed;
      end
    end
  end

  assign busy         = (r_state != ST_IDLE);
  assign done         = r_done;
  assign pass_count   = r_passCount;
  assign error        = r_error;
  assign err_addr     = r_errAddr;
  assign err_expected = r_errExpected;
  assign err_actual   = r_errActual;
  assign read_only    = (r_state != ST_WRITE);
  assign addr         = r_addr;
  assign data_i       = (r_state == ST_WRITE) ? w_pattern : '0;

endmodule

// File: tb/tb_sram_tester.sv
// tb_sram_tester: three tester instances (abort, no-abort, single address), each driving a
// two-cycle-latency SRAM model with injectable stuck-at-1 bits; a queue scoreboard checks them.
module tb_sram_tester;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wrRec_t;

  typedef struct {
    int         cycle;
    logic       err;
    logic [3:0] errAddr;
    logic [7:0] errExp;
    logic [7:0] errAct;
    logic [15:0] passCount;
  } doneRec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic startA = 0, loopA = 0, busyA, doneA, errA, roA;
  logic startB = 0, loopB = 0, busyB, doneB, errB, roB;
  logic startC = 0, loopC = 0, busyC, doneC, errC, roC;
  logic [15:0] pcA, pcB, pcC;
  logic [3:0]  eaA, eaB, eaC, addrA, addrB, addrC;
  logic [7:0]  eeA, eeB, eeC, eactA, eactB, eactC;
  logic [7:0]  dinA, dinB, dinC, doutA, doutB, doutC;
  logic [7:0]  rdA, rdB, rdC;
  logic [7:0]  memA [16], memB [16], memC [16];
  logic [7:0]  faultA [16], faultB [16];

  wrRec_t   qWrA [$];
  doneRec_t qDoneA [$], qDoneB [$], qDoneC [$];
  wrRec_t   monWr;
  doneRec_t monDone;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_tester #(.ADDR_BITS(4), .DATA_BITS(8), .MAX_ADDR(15), .SEED(16'h00A5),
                .READ_LATENCY(2), .STOP_ON_ERROR(1'b1)) dutA (
    .clk(clk), .reset_n(reset_n), .start(startA), .loop(loopA), .busy(busyA), .done(doneA),
    .pass_count(pcA), .error(errA), .err_addr(eaA), .err_expected(eeA), .err_actual(eactA),
    .read_only(roA), .addr(addrA), .data_i(dinA), .data_o(doutA));

  sram_tester #(.ADDR_BITS(4), .DATA_BITS(8), .MAX_ADDR(15), .SEED(16'h00A5),
                .READ_LATENCY(2), .STOP_ON_ERROR(1'b0)) dutB (
    .clk(clk), .reset_n(reset_n), .start(startB), .loop(loopB), .busy(busyB), .done(doneB),
    .pass_count(pcB), .error(errB), .err_addr(eaB), .err_expected(eeB), .err_actual(eactB),
    .read_only(roB), .addr(addrB), .data_i(dinB), .data_o(doutB));

  sram_tester #(.ADDR_BITS(4), .DATA_BITS(8), .MAX_ADDR(0), .SEED(16'h00A5),
                .READ_LATENCY(2), .STOP_ON_ERROR(1'b1)) dutC (
    .clk(clk), .reset_n(reset_n), .start(startC), .loop(loopC), .busy(busyC), .done(doneC),
    .pass_count(pcC), .error(errC), .err_addr(eaC), .err_expected(eeC), .err_actual(eactC),
    .read_only(roC), .addr(addrC), .data_i(dinC), .data_o(doutC));

  // SRAM models: write on the clock edge, read data appears two cycles after the address.
  always @(posedge clk) begin
    if (!roA) memA[addrA] <= dinA;
    if (!roB) memB[addrB] <= dinB;
    if (!roC) memC[addrC] <= dinC;
    rdA   <= memA[addrA] | faultA[addrA];
    rdB   <= memB[addrB] | faultB[addrB];
    rdC   <= memC[addrC];
    doutA <= rdA;
    doutB <= rdB;
    doutC <= rdC;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic checkDone(input string tag, input doneRec_t e, input logic er,
                           input logic [3:0] ea, input logic [7:0] ee, input logic [7:0] eact,
                           input logic [15:0] pc, input logic bsy);
    checkOutput({tag, " done cycle"}, cyc, e.cycle);
    checkOutput({tag, " error"}, 32'(er), 32'(e.err));
    checkOutput({tag, " err_addr"}, 32'(ea), 32'(e.errAddr));
    checkOutput({tag, " err_expected"}, 32'(ee), 32'(e.errExp));
    checkOutput({tag, " err_actual"}, 32'(eact), 32'(e.errAct));
    checkOutput({tag, " pass_count"}, 32'(pc), 32'(e.passCount));
    checkOutput({tag, " busy at done"}, 32'(bsy), 0);
  endtask

  // Monitor: pops an expectation whenever a DUT issues a write or pulses done.
  always @(negedge clk) begin
    if (reset_n) begin
      if (!roA) begin
        checkOutput("A write was expected", 32'(qWrA.size() != 0), 1);
        if (qWrA.size() != 0) begin
          monWr = qWrA.pop_front();
          checkOutput("A write addr", 32'(addrA), 32'(monWr.addr));
          checkOutput("A write data", 32'(dinA), 32'(monWr.data));
        end
      end
      if (doneA) begin
        checkOutput("A done was expected", 32'(qDoneA.size() != 0), 1);
        if (qDoneA.size() != 0) begin
          monDone = qDoneA.pop_front();
          checkDone("A", monDone, errA, eaA, eeA, eactA, pcA, busyA);
        end
      end
      if (doneB) begin
        checkOutput("B done was expected", 32'(qDoneB.size() != 0), 1);
        if (qDoneB.size() != 0) begin
          monDone = qDoneB.pop_front();
          checkDone("B", monDone, errB, eaB, eeB, eactB, pcB, busyB);
        end
      end
      if (doneC) begin
        checkOutput("C done was expected", 32'(qDoneC.size() != 0), 1);
        if (qDoneC.size() != 0) begin
          monDone = qDoneC.pop_front();
          checkDone("C", monDone, errC, eaC, eeC, eactC, pcC, busyC);
        end
      end
      if (busyC) checkOutput("C addr within MAX_ADDR", 32'(addrC), 0);
    end
  end

  task automatic pushWrites(input logic [7:0] seed);
    for (int a = 0; a < 16; a++) qWrA.push_back('{addr: 4'(a), data: 8'(a) ^ seed});
  endtask

  task automatic pushDone(input int inst, input int cycle, input logic er, input logic [3:0] ea,
                          input logic [7:0] ee, input logic [7:0] eact, input logic [15:0] pc);
    doneRec_t r;
    r = '{cycle: cycle, err: er, errAddr: ea, errExp: ee, errAct: eact, passCount: pc};
    case (inst)
      0: qDoneA.push_back(r);
      1: qDoneB.push_back(r);
      default: qDoneC.push_back(r);
    endcase
  endtask

  task automatic applyStimulus(input int inst, output int acceptCyc);
    @(negedge clk);
    case (inst)
      0: startA = 1'b1;
      1: startB = 1'b1;
      default: startC = 1'b1;
    endcase
    @(posedge clk);
    #1 acceptCyc = cyc;
    @(negedge clk);
    startA = 1'b0;
    startB = 1'b0;
    startC = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic waitIdle(input int inst, input string name);
    int n;
    logic b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      b = (inst == 0) ? busyA : (inst == 1) ? busyB : busyC;
    end while (b && n < 400);
    checkOutput({name, " finished within budget"}, 32'(b), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n0;
    int n;
    for (int i = 0; i < 16; i++) begin
      memA[i] = '0; memB[i] = '0; memC[i] = '0; faultA[i] = '0; faultB[i] = '0;
    end
    repeat (3) @(negedge clk);
    checkOutput("reset read_only", 32'(roA), 1);
    checkOutput("reset addr", 32'(addrA), 0);
    checkOutput("reset data_i", 32'(dinA), 0);
    checkOutput("reset busy", 32'(busyA), 0);
    checkOutput("reset pass_count", 32'(pcA), 0);
    checkOutput("reset error", 32'(errA), 0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] single clean pass with an ignored start while busy");
    pushWrites(8'hA5);
    applyStimulus(0, n0);
    pushDone(0, n0 + 35, 1'b0, 4'h0, 8'h00, 8'h00, 16'd1);
    repeat (5) @(negedge clk);
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    waitIdle(0, "A clean pass");

    $display("[TB] three looped passes with alternating seed");
    applyReset();
    pushWrites(8'hA5);
    pushWrites(8'h5A);
    pushWrites(8'hA5);
    loopA = 1'b1;
    applyStimulus(0, n0);
    pushDone(0, n0 + 105, 1'b0, 4'h0, 8'h00, 8'h00, 16'd3);
    n = 0;
    while (pcA != 16'd2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("A loop reached two passes", 32'(pcA), 2);
    loopA = 1'b0;
    waitIdle(0, "A loop");

    $display("[TB] stuck bit at address 6 aborts the pass");
    applyReset();
    faultA[6] = 8'h08;
    pushWrites(8'hA5);
    applyStimulus(0, n0);
    pushDone(0, n0 + 25, 1'b1, 4'd6, 8'hA3, 8'hAB, 16'd0);
    waitIdle(0, "A abort");

    $display("[TB] restart clears error and keeps the seed");
    faultA[6] = 8'h00;
    pushWrites(8'hA5);
    applyStimulus(0, n0);
    pushDone(0, n0 + 35, 1'b0, 4'h0, 8'h00, 8'h00, 16'd1);
    waitIdle(0, "A restart");

    $display("[TB] reset asserted during the read phase");
    pushWrites(8'h5A);
    applyStimulus(0, n0);
    n = 0;
    while (!(roA && busyA && addrA == 4'd7) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("A reached read of addr 7", 32'(roA && busyA && addrA == 4'd7), 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async reset read_only", 32'(roA), 1);
    checkOutput("async reset addr", 32'(addrA), 0);
    checkOutput("async reset busy", 32'(busyA), 0);
    checkOutput("async reset pass_count", 32'(pcA), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    pushWrites(8'hA5);
    applyStimulus(0, n0);
    pushDone(0, n0 + 35, 1'b0, 4'h0, 8'h00, 8'h00, 16'd1);
    waitIdle(0, "A after reset");

    $display("[TB] no-abort instance with two faulty addresses");
    faultB[2] = 8'h10;
    faultB[9] = 8'h10;
    applyStimulus(1, n0);
    pushDone(1, n0 + 35, 1'b1, 4'd2, 8'hA7, 8'hB7, 16'd0);
    waitIdle(1, "B faulty pass");
    faultB[2] = 8'h00;
    faultB[9] = 8'h00;
    applyStimulus(1, n0);
    pushDone(1, n0 + 35, 1'b0, 4'h0, 8'h00, 8'h00, 16'd1);
    waitIdle(1, "B clean pass");

    $display("[TB] single-address instance with start pulsed while busy");
    applyStimulus(2, n0);
    pushDone(2, n0 + 5, 1'b0, 4'h0, 8'h00, 8'h00, 16'd1);
    startC = 1'b1;
    @(negedge clk);
    startC = 1'b0;
    waitIdle(2, "C first pass");
    applyStimulus(2, n0);
    pushDone(2, n0 + 5, 1'b0, 4'h0, 8'h00, 8'h00, 16'd2);
    waitIdle(2, "C second pass");

    checkOutput("A writes left over", 32'(qWrA.size()), 0);
    checkOutput("A done left over", 32'(qDoneA.size()), 0);
    checkOutput("B done left over", 32'(qDoneB.size()), 0);
    checkOutput("C done left over", 32'(qDoneC.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
